mux_4_1: RTL and testbench
==========================

MUX_4_1 -- requirements
Module: mux_4_1

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits; all data ports SHALL use it.
REQ-002 clk  input  1  single clock; all sequential state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 sel  input  2  word select: 0 picks in0, 1 picks in1, 2 picks in2, 3 picks in3.
REQ-005 in0  input  WIDTH  candidate word 0 (cache line bits [15:0] in the I-cache use).
REQ-006 in1  input  WIDTH  candidate word 1 (line bits [31:16]).
REQ-007 in2  input  WIDTH  candidate word 2 (line bits [47:32]).
REQ-008 in3  input  WIDTH  candidate word 3 (line bits [63:48]).
REQ-009 en  input  1  capture enable for the registered output.
REQ-010 out  output  WIDTH  combinational selected word.
REQ-011 out_q  output  WIDTH  registered selected word.
REQ-012 out_q_valid  output  1  high when out_q holds a word captured on the previous edge.
REQ-013 Port order SHALL be sel, in0, in1, in2, in3, out, clk, reset, en, out_q, out_q_valid, so the existing positional instantiation (sel, in0..in3, out) binds unchanged.

Function
REQ-014 out SHALL equal in0/in1/in2/in3 for sel = 0/1/2/3, bit-exact, with no truncation or extension.
REQ-015 out SHALL be purely combinational with zero-cycle latency, and SHALL follow sel or input changes within the same cycle.
REQ-016 out SHALL not depend on clk, reset or en, and SHALL remain valid during reset.
REQ-017 On a clk rising edge with reset=0 and en=1, out_q SHALL load the word selected by the sel value present before the edge.
REQ-018 On a clk rising edge with reset=0 and en=0, out_q SHALL hold its value.
REQ-019 On every clk rising edge with reset=0, out_q_valid SHALL take the value of en, giving a one-cycle capture latency.
REQ-020 reset SHALL take priority over en when both are asserted on the same edge.
REQ-021 Changes to sel or data between edges SHALL not affect out_q.
REQ-022 All four sel codes are legal, so there SHALL be no error or default-zero path.
REQ-023 The block SHALL have no internal state other than out_q and out_q_valid, and no state machine.
REQ-024 Back-to-back en cycles SHALL capture a new word on every edge, with no bubbles.

Reset
REQ-025 While reset=1 at a clk rising edge, out_q SHALL become all zeros and out_q_valid SHALL become 0.
REQ-026 Deasserting reset mid-stream SHALL resume capture on the first edge with reset=0 and en=1.
REQ-027 Before the first reset, out_q and out_q_valid are undefined and SHALL not be relied upon.

Verification
REQ-028 Test: in0=16'h1111, in1=16'h2222, in2=16'h3333, in3=16'h4444, sweep sel 0..3 -> out = 1111, 2222, 3333, 4444 in the same cycle.
REQ-029 Test: reset=1 for one edge -> out_q=0 and out_q_valid=0, while out still tracks sel (sel=2 gives 16'h3333).
REQ-030 Test: en=1 with sel=3 at an edge, then sel=0 mid-cycle -> out_q=16'h4444 and out_q_valid=1 after the edge, and out=16'h1111 immediately.
REQ-031 Test: en=0 for 3 edges while inputs change -> out_q holds 16'h4444 and out_q_valid=0.
REQ-032 Test: reset=1 and en=1 on the same edge -> out_q=0 and out_q_valid=0.
REQ-033 Test: WIDTH=64 with distinct all-ones and alternating patterns on in0..in3 -> full-width bit-exact selection on both out and out_q.

Source files
------------

// File: rtl/mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : mux_4_1
// Purpose  : Four-way word selector with a combinational output and an
//            optional registered copy. It picks one 16-bit word out of a
//            64-bit I-cache line. The registered copy carries a valid flag
//            that is high when the word was captured on the previous edge.
// Revision : 1.0  initial release
// ============================================================================
module mux_4_1 #(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] out_q,
    output logic             out_q_valid
);

    localparam logic [1:0]       C_SEL_W0 = 2'd0;
    localparam logic [1:0]       C_SEL_W1 = 2'd1;
    localparam logic [1:0]       C_SEL_W2 = 2'd2;
    localparam logic [1:0]       C_SEL_W3 = 2'd3;
    localparam logic [WIDTH-1:0] C_ZERO   = '0;

    logic [WIDTH-1:0] w_sel_word;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    // Word select. All four codes are covered, so there is no fallback to
    // zero. The in0 default only keeps the block free of latches.
    always_comb begin
        w_sel_word = in0;
        case (sel)
            C_SEL_W0: w_sel_word = in0;
            C_SEL_W1: w_sel_word = in1;
            C_SEL_W2: w_sel_word = in2;
            C_SEL_W3: w_sel_word = in3;
            default:  w_sel_word = in0;
        endcase
    end

    // The combinational output ignores clk, reset and en, so it stays live
    // through reset.
    assign out = w_sel_word;

    // Next-state logic. Reset wins over en. The valid flag follows en on
    // every edge, which gives a one-cycle capture indication.
    always_comb begin
        data_d  = data_q;
        valid_d = en;
        if (reset) begin
            data_d  = C_ZERO;
            valid_d = 1'b0;
        end else if (en) begin
            data_d  = w_sel_word;
        end
    end

    // Capture registers. Their values before the first reset are undefined.
    always_ff @(posedge clk) begin
        data_q  <= data_d;
        valid_q <= valid_d;
    end

    assign out_q       = data_q;
    assign out_q_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4_1
// Purpose  : Self-checking bench for mux_4_1 at WIDTH=16 and WIDTH=64. It
//            runs directed scenarios followed by randomized traffic, and
//            checks against an array-indexed reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_4_1;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  sel;
    logic [63:0] in_w [4];

    logic [15:0] out16, out_q16;
    logic [63:0] out64, out_q64;
    logic        v16, v64;

    // Reference model state for the registered outputs.
    logic [15:0] m_q16;
    logic [63:0] m_q64;
    logic        m_v;

    int n_cmp = 0;
    int n_err = 0;

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    mux_4_1 #(.WIDTH(16)) u_dut16 (
        .sel         (sel),
        .in0         (in_w[0][15:0]),
        .in1         (in_w[1][15:0]),
        .in2         (in_w[2][15:0]),
        .in3         (in_w[3][15:0]),
        .out         (out16),
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .out_q       (out_q16),
        .out_q_valid (v16)
    );

    mux_4_1 #(.WIDTH(64)) u_dut64 (
        .sel         (sel),
        .in0         (in_w[0]),
        .in1         (in_w[1]),
        .in2         (in_w[2]),
        .in3         (in_w[3]),
        .out         (out64),
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .out_q       (out_q64),
        .out_q_valid (v64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // The model advances on the inputs present before the edge. Outputs are
    // sampled 1 unit after the edge.
    task automatic tick();
        if (reset) begin
            m_q16 = '0;
            m_q64 = '0;
            m_v   = 1'b0;
        end else begin
            m_v = en;
            if (en) begin
                m_q64 = in_w[sel];
                m_q16 = in_w[sel][15:0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb(input string tag);
        logic [63:0] w;
        w = in_w[sel];
        check({tag, ".out16"}, {48'd0, out16}, {48'd0, w[15:0]});
        check({tag, ".out64"}, out64, w);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".outq16"}, {48'd0, out_q16}, {48'd0, m_q16});
        check({tag, ".outq64"}, out_q64, m_q64);
        check({tag, ".valid16"}, {63'd0, v16}, {63'd0, m_v});
        check({tag, ".valid64"}, {63'd0, v64}, {63'd0, m_v});
    endtask

    task automatic set_words(input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] c, input logic [63:0] d);
        in_w[0] = a; in_w[1] = b; in_w[2] = c; in_w[3] = d;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_q16 = '0; m_q64 = '0; m_v = 1'b0;
        reset = 1'b1;
        en    = 1'b0;
        sel   = 2'd0;
        set_words(64'h1111, 64'h2222, 64'h3333, 64'h4444);

        // Sweep sel while reset is held; out must follow within the same cycle.
        for (int s = 0; s < 4; s++) begin
            sel = s[1:0];
            #1;
            check_comb("sweep");
        end
        check("sweep.literal", {48'd0, out16}, 64'h4444);

        // One reset edge with sel=2.
        sel = 2'd2;
        tick();
        check_regs("reset");
        check("reset.out", {48'd0, out16}, 64'h3333);

        // Capture with sel=3, then switch to sel=0 mid-cycle.
        reset = 1'b0; en = 1'b1; sel = 2'd3;
        tick();
        sel = 2'd0;
        #1;
        check_regs("cap");
        check("cap.outq", {48'd0, out_q16}, 64'h4444);
        check("cap.out", {48'd0, out16}, 64'h1111);

        // en low for three edges while the inputs change.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_words({$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom});
            sel = 2'($urandom_range(0, 3));
            tick();
            check_regs("hold");
            check("hold.outq", {48'd0, out_q16}, 64'h4444);
        end

        // reset and en asserted together: reset wins.
        reset = 1'b1; en = 1'b1;
        tick();
        check_regs("rst_en");
        check("rst_en.v", {63'd0, v16}, 64'd0);

        // Full-width patterns with back-to-back captures.
        reset = 1'b0; en = 1'b1;
        set_words(64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA,
                  64'h5555_5555_5555_5555, 64'h0F0F_F0F0_3C3C_C3C3);
        for (int s = 0; s < 4; s++) begin
            sel = s[1:0];
            #1;
            check_comb("wide");
            tick();
            check_regs("wide");
        end
        check("wide.last", out_q64, 64'h0F0F_F0F0_3C3C_C3C3);

        // Reset released mid-stream: capture resumes on the first edge.
        reset = 1'b1; tick();
        reset = 1'b0; en = 1'b1; sel = 2'd1; tick();
        check_regs("resume");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            set_words({$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom});
            sel   = 2'($urandom_range(0, 3));
            en    = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 15) == 0);
            #1;
            check_comb("rand");
            // A mid-cycle change after the first sample must not leak into out_q.
            if ($urandom_range(0, 3) == 0) begin
                logic [1:0] keep_sel;
                logic [63:0] keep_w;
                keep_sel = sel;
                keep_w   = in_w[sel];
                sel = 2'($urandom_range(0, 3));
                in_w[sel] = {$urandom, $urandom};
                #1;
                check_comb("rand.mid");
                sel = keep_sel;
                in_w[keep_sel] = keep_w;
                #1;
            end
            tick();
            check_regs("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
